mbc1_bank_trace: RTL

MBC1_BANK_TRACE -- requirements
Module: mbc1_bank_trace

---
 rtl/mbc1_bank_trace.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mbc1_bank_trace.sv
// mbc1_bank_trace: records every MBC1 low-bank-register write (0x2000-0x3FFF)
// into a small circular history, keeps write/zero statistics and watches the
// written bank values for a three-value unlock sequence.
//
// Build option: define MBC1_TRACE_FIXUP_EN to store the effective MBC1 bank
// (a written low value of 0 is stored as 1). Without it entries are stored raw.
// The zero flag and the unlock FSM always look at the raw written value.
//
// Interface timing: there is no handshake. Every rising edge of ROM_BANK_CLK
// is exactly one completed bank write; GB_DQ and BANK_HI are sampled on that
// edge. The history, counters, zero flag and FSM all update on the same edge.
// RD_IDX -> RD_DATA/RD_VALID is purely combinational.
module mbc1_bank_trace #(
  parameter int         DEPTH     = 8,
  parameter logic [4:0] UNLOCK_B0 = 5'h15,
  parameter logic [4:0] UNLOCK_B1 = 5'h0A,
  parameter logic [4:0] UNLOCK_B2 = 5'h1F
) (
  input  logic        ROM_BANK_CLK,
  input  logic        GB_RST,
  input  logic [7:0]  GB_DQ,
  input  logic [1:0]  BANK_HI,
  input  logic [2:0]  RD_IDX,
  output logic [6:0]  RD_DATA,
  output logic        RD_VALID,
  output logic [3:0]  WR_COUNT,
  output logic [15:0] TOTAL_WRITES,
  output logic        ZERO_SEEN,
  output logic        UNLOCK,
  output logic [1:0]  SEQ_STATE
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT1     = 2'd1,
    GOT2     = 2'd2,
    UNLOCKED = 2'd3
  } seq_state_t;

  // History storage is deliberately not reset; validity comes from wr_count_q.
  logic [6:0]    mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [3:0]    wr_count_q, wr_count_d;
  logic [15:0]   total_q, total_d;
  logic          zero_q, zero_d;
  seq_state_t    state_q, state_d;

  logic [4:0]    raw_v;
  logic [4:0]    store_v;
  logic          raw_zero;
  logic [6:0]    entry;
  logic [PW-1:0] rd_ptr;
  logic          unused_dq;

  // Upper data bits are not part of the MBC1 low bank register.
  assign unused_dq = ^GB_DQ[7:5];

  assign raw_v    = GB_DQ[4:0];
  assign raw_zero = (raw_v == 5'd0);

`ifdef MBC1_TRACE_FIXUP_EN
  // MBC1 maps a written low value of 0 to bank 1; store what the cart selects.
  assign store_v = raw_zero ? 5'd1 : raw_v;
`else
  assign store_v = raw_v;
`endif

  assign entry = {BANK_HI, store_v};

  // Next-state for pointer, counters and sticky zero flag.
  always_comb begin
    wp_d       = wp_q + PW'(1);
    wr_count_d = (wr_count_q == 4'(DEPTH)) ? wr_count_q : wr_count_q + 4'd1;
    total_d    = (&total_q) ? total_q : total_q + 16'd1;
    zero_d     = zero_q | raw_zero;
  end

  // Unlock sequence FSM next-state; UNLOCKED is absorbing until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (raw_v == UNLOCK_B0) state_d = GOT1;
        else                    state_d = IDLE;
      end
      GOT1: begin
        if      (raw_v == UNLOCK_B1) state_d = GOT2;
        else if (raw_v == UNLOCK_B0) state_d = GOT1;
        else                         state_d = IDLE;
      end
      GOT2: begin
        if      (raw_v == UNLOCK_B2) state_d = UNLOCKED;
        else if (raw_v == UNLOCK_B0) state_d = GOT1;
        else                         state_d = IDLE;
      end
      UNLOCKED: state_d = UNLOCKED;
      default:  state_d = IDLE;
    endcase
  end

  // Control/status registers, cleared asynchronously while GB_RST is low.
  always_ff @(posedge ROM_BANK_CLK or negedge GB_RST) begin
    if (!GB_RST) begin
      wp_q       <= '0;
      wr_count_q <= '0;
      total_q    <= '0;
      zero_q     <= 1'b0;
      state_q    <= IDLE;
    end else begin
      wp_q       <= wp_d;
      wr_count_q <= wr_count_d;
      total_q    <= total_d;
      zero_q     <= zero_d;
      state_q    <= state_d;
    end
  end

  // History write: one entry per bank write at the current write pointer.
  always_ff @(posedge ROM_BANK_CLK) begin
    mem_q[wp_q] <= entry;
  end

  // Read port: index 0 is the most recent write, counting back in time.
  always_comb begin
    rd_ptr   = wp_q - PW'(1) - PW'(RD_IDX);
    RD_VALID = ({1'b0, RD_IDX} < wr_count_q);
    RD_DATA  = RD_VALID ? mem_q[rd_ptr] : 7'd0;
  end

  assign WR_COUNT     = wr_count_q;
  assign TOTAL_WRITES = total_q;
  assign ZERO_SEEN    = zero_q;
  assign SEQ_STATE    = state_q;
  assign UNLOCK       = (state_q == UNLOCKED);

endmodule
